imem_loader: RTL and testbench

- Writer side of the instruction memory. Accepts a byte stream over a valid/ready handshake, typically from a UART receiver or debug port.
- Assembles the bytes into little-endian 32-bit instruction words and writes them into Instruction_Mem through its write port, one word per write strobe.
- Holds the fetch stage in stall until the program image is fully loaded.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_byte_word_packer.sv | 39 +++
 rtl/imem_loader.sv | 181 ++++++++++++++++++
 tb/tb_imem_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: types and constants shared by the instruction-memory loader.
//   state_t           - loader FSM states
//   BYTES_PER_WORD    - bytes per instruction word (little-endian assembly)
//   DEFAULT_BASE_ADDR - default byte address of the first written word
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam int          BYTES_PER_WORD    = 4;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// byte_word_packer: collects 4 bytes little-endian (first byte -> bits 7:0).
// Ports:
//   clk          - system clock
//   reset_n_i    - synchronous active-low reset
//   shift_en_i   - a byte is being accepted this cycle
//   byte_i       - the byte being accepted
//   word_o       - assembled word including the byte on byte_i (valid with word_ready_o)
//   word_ready_o - this cycle's byte completes a word
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        shift_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    logic [1:0]  idx_q;
    // Only the three earlier bytes need storage; the fourth is taken straight
    // from byte_i so the word is usable on the same edge it completes.
    logic [23:0] word_q;

    assign word_o       = {byte_i, word_q};
    assign word_ready_o = shift_en_i && (idx_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            idx_q  <= 2'd0;
            word_q <= 24'd0;
        end else if (shift_en_i) begin
            // 2-bit index wraps back to 0 after the fourth byte.
            idx_q  <= idx_q + 2'd1;
            word_q <= {byte_i, word_q[23:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory. Receives a byte stream
// (4-byte little-endian word count N followed by N little-endian words),
// writes each word to instruction memory and stalls fetch until done.
// Optional: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum
// byte over all data bytes before the load is declared done.
// Ports:
//   clk, reset (sync, active-low), start (load request pulse)
//   byte_in/byte_valid/byte_ready  - byte stream handshake
//   mem_write_en/addr/data         - instruction memory write port
//   cpu_hold, load_done, load_error, words_written - status
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          MAX_WORDS   = 256,
    parameter int          COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    output logic                   mem_write_en,
    output logic [31:0]            mem_write_addr,
    output logic [31:0]            mem_write_data,
    output logic                   cpu_hold,
    output logic                   load_done,
    output logic                   load_error,
    output logic [COUNT_WIDTH-1:0] words_written
);

    state_t                 state_q;
    logic [31:0]            len_q;
    logic [COUNT_WIDTH-1:0] words_q;
    logic                   byte_ready_q;
    logic                   mem_write_en_q;
    logic [31:0]            mem_write_addr_q;
    logic [31:0]            mem_write_data_q;
    logic                   cpu_hold_q;
    logic                   load_done_q;
    logic                   load_error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]             csum_q;
`endif

    logic                   xfer;
    logic                   shift_en;
    logic [31:0]            word;
    logic                   word_ready;
    logic [COUNT_WIDTH-1:0] words_inc;

    assign xfer      = byte_valid && byte_ready_q;
    assign shift_en  = xfer && ((state_q == LEN) || (state_q == DATA));
    assign words_inc = words_q + COUNT_WIDTH'(1);

    byte_word_packer u_packer (
        .clk          (clk),
        .reset_n_i    (reset),
        .shift_en_i   (shift_en),
        .byte_i       (byte_in),
        .word_o       (word),
        .word_ready_o (word_ready)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= IDLE;
            len_q            <= 32'd0;
            words_q          <= '0;
            byte_ready_q     <= 1'b0;
            mem_write_en_q   <= 1'b0;
            mem_write_addr_q <= BASE_ADDR;
            mem_write_data_q <= 32'd0;
            cpu_hold_q       <= 1'b0;
            load_done_q      <= 1'b0;
            load_error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q           <= 8'd0;
`endif
        end else begin
            // Strobe is a single-cycle pulse unless re-armed below.
            mem_write_en_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_q      <= LEN;
                        byte_ready_q <= 1'b1;
                        cpu_hold_q   <= 1'b1;
                        load_done_q  <= 1'b0;
                        load_error_q <= 1'b0;
                        words_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q       <= 8'd0;
`endif
                    end
                end
                LEN: begin
                    if (word_ready) begin
                        len_q <= word;
                        if (word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_q      <= CHECK;
`else
                            state_q      <= DONE;
                            byte_ready_q <= 1'b0;
                            cpu_hold_q   <= 1'b0;
                            load_done_q  <= 1'b1;
`endif
                        end else if (word > 32'(MAX_WORDS)) begin
                            state_q      <= ERROR;
                            byte_ready_q <= 1'b0;
                            cpu_hold_q   <= 1'b0;
                            load_error_q <= 1'b1;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (xfer) csum_q <= csum_q ^ byte_in;
`endif
                    if (word_ready) begin
                        state_q          <= WRITE;
                        byte_ready_q     <= 1'b0;
                        mem_write_en_q   <= 1'b1;
                        mem_write_addr_q <= BASE_ADDR + (32'(words_q) << 2);
                        mem_write_data_q <= word;
                    end
                end
                WRITE: begin
                    words_q <= words_inc;
                    if (32'(words_inc) == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_q      <= CHECK;
                        byte_ready_q <= 1'b1;
`else
                        state_q      <= DONE;
                        cpu_hold_q   <= 1'b0;
                        load_done_q  <= 1'b1;
`endif
                    end else begin
                        state_q      <= DATA;
                        byte_ready_q <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (xfer) begin
                        byte_ready_q <= 1'b0;
                        cpu_hold_q   <= 1'b0;
                        if (byte_in == csum_q) begin
                            state_q     <= DONE;
                            load_done_q <= 1'b1;
                        end else begin
                            state_q      <= ERROR;
                            load_error_q <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q      <= IDLE;
                    byte_ready_q <= 1'b0;
                    cpu_hold_q   <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready     = byte_ready_q;
    assign mem_write_en   = mem_write_en_q;
    assign mem_write_addr = mem_write_addr_q;
    assign mem_write_data = mem_write_data_q;
    assign cpu_hold       = cpu_hold_q;
    assign load_done      = load_done_q;
    assign load_error     = load_error_q;
    assign words_written  = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
// Builds with or without IMEM_LOADER_CHECKSUM_EN; checksum scenarios run only
// when the macro is defined.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_write_en;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_written;

    int total = 0;
    int bad   = 0;

    // Write monitor: one entry per cycle that mem_write_en is high.
    int          wr_cnt = 0;
    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];

    imem_loader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .byte_in        (byte_in),
        .byte_valid     (byte_valid),
        .byte_ready     (byte_ready),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .cpu_hold       (cpu_hold),
        .load_done      (load_done),
        .load_error     (load_error),
        .words_written  (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_write_en === 1'b1) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = mem_write_addr;
                wr_data[wr_cnt] = mem_write_data;
            end
            wr_cnt = wr_cnt + 1;
            $display("write: addr=%08h data=%08h", mem_write_addr, mem_write_data);
        end
    end

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL send_byte timeout byte=%02h got byte_ready=%0b required=1", b, byte_ready);
        end else begin
            @(posedge clk);
            @(negedge clk);
            $display("byte: %02h", b);
        end
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (load_done !== 1'b1 && load_error !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL %s wait_end timeout got done=%0b error=%0b required one set", name, load_done, load_error);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_in = 8'h00;
        repeat (3) @(negedge clk);
        total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL reset byte_ready got=%0b required=0", byte_ready); end
        total++; if (mem_write_en !== 1'b0) begin bad++; $display("FAIL reset mem_write_en got=%0b required=0", mem_write_en); end
        total++; if (mem_write_addr !== 32'h0) begin bad++; $display("FAIL reset addr got=%08h required=00000000", mem_write_addr); end
        total++; if (mem_write_data !== 32'h0) begin bad++; $display("FAIL reset data got=%08h required=00000000", mem_write_data); end
        total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL reset cpu_hold got=%0b required=0", cpu_hold); end
        total++; if (load_done !== 1'b0 || load_error !== 1'b0) begin bad++; $display("FAIL reset flags got done=%0b error=%0b required 0/0", load_done, load_error); end
        total++; if (words_written !== 16'd0) begin bad++; $display("FAIL reset words_written got=%0d required=0", words_written); end
        reset = 1'b1;
        @(negedge clk);
        total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL idle byte_ready got=%0b required=0", byte_ready); end
    endtask

    // Shared body of the normal and gapped 2-word loads.
    task automatic load_two_words(input string name, input bit gap);
        int base;
        base = wr_cnt;
        pulse_start();
        total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL %s cpu_hold got=%0b required=1", name, cpu_hold); end
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05);
        if (gap) begin
            repeat (3) @(negedge clk);
            total++; if (wr_cnt != base) begin bad++; $display("FAIL %s gap strobe got=%0d required=0", name, wr_cnt - base); end
        end
        send_byte(8'hA0); send_byte(8'h00);
        // Strobe must be present one cycle after the word's 4th byte.
        total++; if (mem_write_en !== 1'b1) begin bad++; $display("FAIL %s latency mem_write_en got=%0b required=1", name, mem_write_en); end
        send_byte(8'h93); send_byte(8'h05); send_byte(8'h50); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h70);
`endif
        wait_end(name);
        total++; if (wr_cnt - base != 2) begin bad++; $display("FAIL %s write count got=%0d required=2", name, wr_cnt - base); end
        total++; if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h00A00513) begin bad++; $display("FAIL %s word0 got addr=%08h data=%08h required 00000000/00A00513", name, wr_addr[base], wr_data[base]); end
        total++; if (wr_addr[base+1] !== 32'h4 || wr_data[base+1] !== 32'h00500593) begin bad++; $display("FAIL %s word1 got addr=%08h data=%08h required 00000004/00500593", name, wr_addr[base+1], wr_data[base+1]); end
        total++; if (load_done !== 1'b1 || load_error !== 1'b0) begin bad++; $display("FAIL %s flags got done=%0b error=%0b required 1/0", name, load_done, load_error); end
        total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL %s end cpu_hold got=%0b required=0", name, cpu_hold); end
        total++; if (words_written !== 16'd2) begin bad++; $display("FAIL %s words_written got=%0d required=2", name, words_written); end
        total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL %s end byte_ready got=%0b required=0", name, byte_ready); end
    endtask

    task automatic test_two_words();
        load_two_words("two_words", 1'b0);
    endtask

    task automatic test_gapped();
        load_two_words("gapped", 1'b1);
    endtask

    task automatic test_zero_length();
        int base;
        base = wr_cnt;
        pulse_start();
        total++; if (load_done !== 1'b0 || words_written !== 16'd0) begin bad++; $display("FAIL zero_len restart got done=%0b words=%0d required 0/0", load_done, words_written); end
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        wait_end("zero_len");
        total++; if (load_done !== 1'b1 || load_error !== 1'b0) begin bad++; $display("FAIL zero_len flags got done=%0b error=%0b required 1/0", load_done, load_error); end
        total++; if (wr_cnt != base) begin bad++; $display("FAIL zero_len writes got=%0d required=0", wr_cnt - base); end
        total++; if (words_written !== 16'd0 || cpu_hold !== 1'b0) begin bad++; $display("FAIL zero_len state got words=%0d hold=%0b required 0/0", words_written, cpu_hold); end
    endtask

    task automatic test_over_limit();
        int base;
        base = wr_cnt;
        pulse_start();
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        wait_end("over_limit");
        total++; if (load_error !== 1'b1 || load_done !== 1'b0) begin bad++; $display("FAIL over_limit flags got done=%0b error=%0b required 0/1", load_done, load_error); end
        total++; if (wr_cnt != base) begin bad++; $display("FAIL over_limit writes got=%0d required=0", wr_cnt - base); end
        total++; if (byte_ready !== 1'b0 || cpu_hold !== 1'b0) begin bad++; $display("FAIL over_limit ready/hold got=%0b/%0b required 0/0", byte_ready, cpu_hold); end
    endtask

    task automatic test_reset_mid_load();
        int base;
        base = wr_cnt;
        pulse_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05);
        reset = 1'b0;
        @(negedge clk);
        total++; if (byte_ready !== 1'b0 || mem_write_en !== 1'b0) begin bad++; $display("FAIL mid_reset ready/strobe got=%0b/%0b required 0/0", byte_ready, mem_write_en); end
        total++; if (mem_write_addr !== 32'h0 || mem_write_data !== 32'h0) begin bad++; $display("FAIL mid_reset addr/data got=%08h/%08h required 0/0", mem_write_addr, mem_write_data); end
        total++; if (cpu_hold !== 1'b0 || load_done !== 1'b0 || load_error !== 1'b0) begin bad++; $display("FAIL mid_reset status got hold=%0b done=%0b error=%0b required 0/0/0", cpu_hold, load_done, load_error); end
        total++; if (words_written !== 16'd0 || wr_cnt != base) begin bad++; $display("FAIL mid_reset count got words=%0d writes=%0d required 0/0", words_written, wr_cnt - base); end
        reset = 1'b1;
        @(negedge clk);
        load_two_words("after_reset", 1'b0);
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int base;
        base = wr_cnt;
        pulse_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h44);
        wait_end("csum_ok");
        total++; if (load_done !== 1'b1 || load_error !== 1'b0) begin bad++; $display("FAIL csum_ok flags got done=%0b error=%0b required 1/0", load_done, load_error); end
        total++; if (wr_cnt - base != 1 || wr_data[base] !== 32'h44332211) begin bad++; $display("FAIL csum_ok write got n=%0d data=%08h required 1/44332211", wr_cnt - base, wr_data[base]); end
        base = wr_cnt;
        pulse_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h45);
        wait_end("csum_bad");
        total++; if (load_error !== 1'b1 || load_done !== 1'b0) begin bad++; $display("FAIL csum_bad flags got done=%0b error=%0b required 0/1", load_done, load_error); end
        total++; if (wr_cnt - base != 1 || wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h44332211) begin bad++; $display("FAIL csum_bad write got n=%0d addr=%08h data=%08h required 1/0/44332211", wr_cnt - base, wr_addr[base], wr_data[base]); end
        total++; if (words_written !== 16'd1) begin bad++; $display("FAIL csum_bad words_written got=%0d required=1", words_written); end
    endtask
`endif

    initial begin
        reset = 1'b0;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_in = 8'h00;
        @(negedge clk);
        test_reset();
        test_two_words();
        test_zero_length();
        test_over_limit();
        test_gapped();
        test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
